// File: rtl/tone_period_decoder.sv
// Tone period decoder: measures the half-period of a square wave and maps it
// back onto the 21-entry note table (C..B x normal/up/down octave).
module tone_period_decoder #(
  parameter int unsigned TOL_SHIFT      = 6,
  parameter int unsigned STABLE_COUNT   = 2,
  parameter int unsigned SILENCE_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [2:0]  key_id,
  output logic        octave_up,
  output logic        octave_down,
  output logic        note_valid,
  output logic [18:0] half_period,
  output logic        note_change_pulse
);

  localparam int unsigned CNT_W    = 19;
  localparam int unsigned MW       = 20;
  localparam int unsigned NOTE_W   = 5;
  localparam int unsigned STREAK_W = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0]    SIL        = CNT_W'(SILENCE_CYCLES);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STABLE_COUNT);

  logic              r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_armed;
  logic              r_cls_stb, r_cls_hit;
  logic [NOTE_W-1:0] r_cls_note;
  logic [NOTE_W-1:0] r_cand;
  logic [STREAK_W-1:0] r_streak;
  logic [NOTE_W:0]   r_fields_d;

  logic              w_edge, w_cnt_sat, w_silence, w_hit;
  logic [MW-1:0]     w_meas;
  logic [NOTE_W-1:0] w_note;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic [NOTE_W:0]   w_fields;

  function automatic logic [MW-1:0] base_period(input logic [2:0] key);
    case (key)
      3'd1:    base_period = 20'd95567;
      3'd2:    base_period = 20'd85136;
      3'd3:    base_period = 20'd75831;
      3'd4:    base_period = 20'd71570;
      3'd5:    base_period = 20'd63776;
      3'd6:    base_period = 20'd56818;
      3'd7:    base_period = 20'd50620;
      default: base_period = '0;
    endcase
  endfunction

  // oct: 0 = normal, 1 = up (N/2 truncated), 2 = down (2N)
  function automatic logic [MW-1:0] table_period(input logic [2:0] key, input logic [1:0] oct);
    logic [MW-1:0] n;
    n = base_period(key);
    case (oct)
      2'd1:    table_period = n >> 1;
      2'd2:    table_period = n << 1;
      default: table_period = n;
    endcase
  endfunction

  function automatic logic in_range(input logic [MW-1:0] m, input logic [MW-1:0] t);
    logic [MW-1:0] diff;
    diff     = (m >= t) ? (m - t) : (t - m);
    in_range = (diff <= (t >> TOL_SHIFT));
  endfunction

  assign w_edge    = r_sync2 ^ r_prev;
  assign w_cnt_sat = (r_cnt == SIL);
  assign w_silence = w_cnt_sat && !w_edge;
  assign w_meas    = MW'(r_cnt) + MW'(1);
  assign w_fields  = {note_valid, key_id, octave_up, octave_down};

  // Scan from the highest index down so the lowest matching index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_note = '0;
    for (int oct = 2; oct >= 0; oct--) begin
      for (int k = 7; k >= 1; k--) begin
        if (in_range(w_meas, table_period(3'(k), 2'(oct)))) begin
          w_hit  = 1'b1;
          w_note = {3'(k), (oct == 1), (oct == 2)};
        end
      end
    end
  end

  // A cleared candidate never equals a real match, so a plain compare suffices.
  always_comb begin
    w_streak_nxt = STREAK_W'(1);
    if (r_cls_note == r_cand && r_streak != '0)
      w_streak_nxt = (r_streak == STREAK_MAX) ? r_streak : r_streak + STREAK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Period counter, arming and half-period capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      half_period <= '0;
    end else if (w_edge) begin
      r_cnt <= '0;
      if (!r_armed)
        r_armed <= 1'b1;
      else
        half_period <= (w_meas > MW'(SILENCE_CYCLES)) ? SIL : w_meas[CNT_W-1:0];
    end else if (w_cnt_sat) begin
      r_armed     <= 1'b0;
      half_period <= SIL;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls_stb  <= 1'b0;
      r_cls_hit  <= 1'b0;
      r_cls_note <= '0;
    end else begin
      r_cls_stb  <= w_edge && r_armed;
      r_cls_hit  <= w_hit;
      r_cls_note <= w_note;
    end
  end

  // Streak tracking and output update; silence overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand      <= '0;
      r_streak    <= '0;
      key_id      <= '0;
      octave_up   <= 1'b0;
      octave_down <= 1'b0;
      note_valid  <= 1'b0;
    end else if (w_silence) begin
      r_cand      <= '0;
      r_streak    <= '0;
      key_id      <= '0;
      octave_up   <= 1'b0;
      octave_down <= 1'b0;
      note_valid  <= 1'b0;
    end else if (r_cls_stb) begin
      if (!r_cls_hit) begin
        r_cand   <= '0;
        r_streak <= '0;
      end else begin
        r_cand   <= r_cls_note;
        r_streak <= w_streak_nxt;
        if (w_streak_nxt >= STREAK_MAX) begin
          key_id      <= r_cls_note[4:2];
          octave_up   <= r_cls_note[1];
          octave_down <= r_cls_note[0];
          note_valid  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fields_d        <= '0;
      note_change_pulse <= 1'b0;
    end else begin
      r_fields_d        <= w_fields;
      note_change_pulse <= (w_fields != r_fields_d);
    end
  end

endmodule

// File: tb/tb_tone_period_decoder.sv
// Bench for tone_period_decoder: table-driven tone sequences plus a pulse
// scoreboard that pops an expected note on every note_change_pulse.
module tb_tone_period_decoder;

  localparam int SIL = 400000;

  typedef struct packed {
    logic       valid;
    logic [2:0] key;
    logic       up;
    logic       dn;
  } exp_t;

  typedef struct {
    int         half;
    int         reps;
    int         jit;
    logic [2:0] key;
    logic       up;
    logic       dn;
    logic       chg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [2:0]  key_id;
  logic        octave_up, octave_down, note_valid, note_change_pulse;
  logic [18:0] half_period;

  int   n_checks = 0;
  int   n_pass = 0;
  int   slack = 0;
  int   both_cnt = 0;
  int   exp_pulses = 0;
  int   got_pulses = 0;
  exp_t q[$];

  tone_period_decoder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tone_in          (tone_in),
    .key_id           (key_id),
    .octave_up        (octave_up),
    .octave_down      (octave_down),
    .note_valid       (note_valid),
    .half_period      (half_period),
    .note_change_pulse(note_change_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each call produces one tone edge exactly h cycles after the previous one.
  task automatic half_cycle(input int h);
    wait_n(h - slack);
    slack   = 0;
    tone_in = ~tone_in;
  endtask

  task automatic push(input logic v, input logic [2:0] k, input logic u, input logic d);
    q.push_back('{valid: v, key: k, up: u, dn: d});
    exp_pulses++;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [2:0] k,
                           input logic u, input logic d);
    check({tag, "_valid"}, int'(note_valid), int'(v));
    check({tag, "_key"},   int'(key_id),     int'(k));
    check({tag, "_up"},    int'(octave_up),  int'(u));
    check({tag, "_down"},  int'(octave_down), int'(d));
  endtask

  // Scoreboard: every pulse must correspond to a queued expected note.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (octave_up && octave_down) both_cnt++;
      if (note_change_pulse) begin
        got_pulses++;
        if (q.size() == 0) begin
          check("unexpected_pulse", int'(note_change_pulse), 0);
        end else begin
          e = q.pop_front();
          check("sb_valid", int'(note_valid), int'(e.valid));
          check("sb_key",   int'(key_id),     int'(e.key));
          check("sb_up",    int'(octave_up),  int'(e.up));
          check("sb_down",  int'(octave_down), int'(e.dn));
        end
      end
    end
  end

  initial begin
    repeat (3_000_000) @(posedge clk);
    n_checks++;
    $display("FAIL watchdog: got timeout, expected normal finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   alt[4];
    int   h;

    vecs[0] = '{half: 47783,  reps: 2, jit: 0,   key: 3'd1, up: 1'b1, dn: 1'b0, chg: 1'b1};
    vecs[1] = '{half: 191134, reps: 2, jit: 0,   key: 3'd1, up: 1'b0, dn: 1'b1, chg: 1'b1};
    vecs[2] = '{half: 56818,  reps: 2, jit: 700, key: 3'd6, up: 1'b0, dn: 1'b0, chg: 1'b1};
    vecs[3] = '{half: 51410,  reps: 2, jit: 0,   key: 3'd7, up: 1'b0, dn: 1'b0, chg: 1'b1};
    vecs[4] = '{half: 51411,  reps: 1, jit: 0,   key: 3'd7, up: 1'b0, dn: 1'b0, chg: 1'b0};
    vecs[5] = '{half: 49830,  reps: 2, jit: 0,   key: 3'd7, up: 1'b0, dn: 1'b0, chg: 1'b0};
    alt = '{56818, 63776, 56818, 63776};
    h = 0;

    // Reset state
    wait_n(5);
    check_out("rst", 1'b0, 3'd0, 1'b0, 1'b0);
    check("rst_half", int'(half_period), 0);
    check("rst_pulse", int'(note_change_pulse), 0);
    rst_n = 1'b1;
    wait_n(2);

    // C4: arm, then two matching half-periods
    tone_in = ~tone_in;
    half_cycle(95567);
    push(1'b1, 3'd1, 1'b0, 1'b0);
    half_cycle(95567);
    wait_n(3);
    check("c_early_valid", int'(note_valid), 0);
    check("c_half", int'(half_period), 95567);
    wait_n(1);
    check_out("c", 1'b1, 3'd1, 1'b0, 1'b0);
    slack = 4;

    // Octave changes, jitter, tolerance boundaries, re-confirmation
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < vecs[i].reps; p++) begin
        h = vecs[i].half;
        if (vecs[i].jit != 0)
          h = h + int'($urandom_range(2 * vecs[i].jit)) - vecs[i].jit;
        if (p == vecs[i].reps - 1 && vecs[i].chg)
          push(1'b1, vecs[i].key, vecs[i].up, vecs[i].dn);
        half_cycle(h);
      end
      wait_n(4);
      slack = 4;
      check_out($sformatf("vec%0d", i), 1'b1, vecs[i].key, vecs[i].up, vecs[i].dn);
      check($sformatf("vec%0d_half", i), int'(half_period), h);
    end

    // G4 then silence
    half_cycle(63776);
    push(1'b1, 3'd5, 1'b0, 1'b0);
    half_cycle(63776);
    wait_n(4);
    check_out("g", 1'b1, 3'd5, 1'b0, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0);
    wait_n(SIL - 1);
    check("sil_before_valid", int'(note_valid), 1);
    wait_n(1);
    check_out("sil", 1'b0, 3'd0, 1'b0, 1'b0);
    check("sil_half", int'(half_period), SIL);
    tone_in = ~tone_in;
    wait_n(4);
    slack = 4;
    check("rearm_valid", int'(note_valid), 0);
    check("rearm_half", int'(half_period), SIL);

    // Out-of-table period, then alternating notes that never build a streak
    half_cycle(65000);
    half_cycle(65000);
    wait_n(4);
    slack = 4;
    check("nomatch_valid", int'(note_valid), 0);
    check("nomatch_half", int'(half_period), 65000);
    for (int i = 0; i < 4; i++) half_cycle(alt[i]);
    wait_n(4);
    slack = 4;
    check_out("alt", 1'b0, 3'd0, 1'b0, 1'b0);
    check("alt_half", int'(half_period), 63776);

    // A4 valid, then reset mid-tone
    half_cycle(56818);
    push(1'b1, 3'd6, 1'b0, 1'b0);
    half_cycle(56818);
    wait_n(4);
    slack = 4;
    check_out("a", 1'b1, 3'd6, 1'b0, 1'b0);
    if (tone_in) half_cycle(56818);
    wait_n(1000);
    rst_n = 1'b0;
    #1;
    check_out("midrst", 1'b0, 3'd0, 1'b0, 1'b0);
    check("midrst_half", int'(half_period), 0);
    wait_n(3);
    rst_n = 1'b1;
    slack = 0;
    wait_n(10);
    tone_in = ~tone_in;
    half_cycle(56818);
    wait_n(4);
    slack = 4;
    check("post_rst_2edges_valid", int'(note_valid), 0);
    push(1'b1, 3'd6, 1'b0, 1'b0);
    half_cycle(56818);
    wait_n(4);
    check_out("post_rst", 1'b1, 3'd6, 1'b0, 1'b0);
    wait_n(4);

    check("sb_queue_empty", q.size(), 0);
    check("pulse_count", got_pulses, exp_pulses);
    check("octave_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
